// File: rtl/spi_pkg.sv
// spi_pkg
// Shared definitions for the parametrised SPI slave:
//   MODE0..MODE3  {CPOL, CPHA} encodings of the four SPI modes
//   state_t       frame FSM states
//   SYNC_STAGES   depth of the pin synchronisers
package spi_pkg;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/spi_sync.sv
// spi_sync
// Multi-flop synchroniser for an asynchronous input, with optional
// registered rise/fall pulses.
// Ports:
//   clk, rst_n   system clock, synchronous active-low reset
//   d            asynchronous input
//   q            synchronised level (edge register output when EDGES=1)
//   rise, fall   one-clk pulses on a synchronised 0->1 / 1->0 change
//                (tied low when EDGES=0)
module spi_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0,
  parameter bit          EDGES   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= {STAGES{RST_VAL}};
    end else begin
      sync <= {sync[STAGES-2:0], d};
    end
  end

  if (EDGES) begin : g_edges
    logic            prev;
    logic            rise_r;
    logic            fall_r;
    logic [STAGES:0] warm;

    // Pulses stay masked until every stage holds a real sample after
    // reset, so a pin already away from RST_VAL does not look like an edge.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        prev   <= RST_VAL;
        rise_r <= 1'b0;
        fall_r <= 1'b0;
        warm   <= '0;
      end else begin
        prev   <= sync[STAGES-1];
        warm   <= {warm[STAGES-1:0], 1'b1};
        rise_r <= warm[STAGES] &  sync[STAGES-1] & ~prev;
        fall_r <= warm[STAGES] & ~sync[STAGES-1] &  prev;
      end
    end

    assign q    = prev;
    assign rise = rise_r;
    assign fall = fall_r;
  end else begin : g_level
    assign q    = sync[STAGES-1];
    assign rise = 1'b0;
    assign fall = 1'b0;
  end

endmodule

// File: rtl/spi_slave_param.sv
// spi_slave_param
// Oversampled SPI slave with run-time mode selection, parametrised word
// width and bit order, gapless back-to-back words while CS stays low,
// a TX holding register and an RX valid/ack handshake.
// Ports:
//   clk, rst_n        system clock, synchronous active-low reset
//   SCLK, CS, MOSI    asynchronous SPI pins from the master (CS active-low)
//   MISO              registered slave output, 0 outside a frame
//   mode              {CPOL, CPHA}, captured when a frame starts
//   load, data_in     one-clk write of the TX holding register
//   tx_full           holding register occupied
//   rx, rx_valid      last completed word, unread flag
//   rx_ack            host consumed rx
//   done              one-clk pulse per completed word
//   overrun           word completed while the previous one was unread
//   underrun          TX_IDLE loaded because nothing was held
//   busy              frame in progress
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter bit                LSB_FIRST = 1'b0,
  parameter logic [DATA_W-1:0] TX_IDLE   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SCLK,
  input  logic              CS,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [1:0]        mode,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  output logic              tx_full,
  output logic [DATA_W-1:0] rx,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              done,
  output logic              overrun,
  output logic              underrun,
  output logic              busy
);

  localparam int unsigned     CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  // ---------------------------------------------------------------
  // Pin synchronisers
  // ---------------------------------------------------------------
  logic sclk_q, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGES(1'b1)) u_sclk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (SCLK),
    .q    (sclk_q),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1), .EDGES(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (CS),
    .q    (cs_q),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGES(1'b0)) u_mosi_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (MOSI),
    .q    (mosi_s),
    .rise (mosi_rise),
    .fall (mosi_fall)
  );

  assign unused_sync = ^{sclk_q, cs_q, mosi_rise, mosi_fall};

  // ---------------------------------------------------------------
  // State
  // ---------------------------------------------------------------
  state_t            state;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] tx_hold;
  logic [DATA_W-1:0] tx_shreg;
  logic [DATA_W-1:0] rx_shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              reload_pending;
  logic              miso_gate;

  // ---------------------------------------------------------------
  // Edge classification and datapath helpers
  // ---------------------------------------------------------------
  logic              cpol, cpha;
  logic              lead_edge, trail_edge;
  logic              sample_edge, drive_edge;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] tx_shifted;
  logic [DATA_W-1:0] rx_next;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? w[0] : w[DATA_W-1];
  endfunction

  always_comb begin
    cpol        = mode_q[1];
    cpha        = mode_q[0];
    lead_edge   = cpol ? sclk_fall : sclk_rise;
    trail_edge  = cpol ? sclk_rise : sclk_fall;
    sample_edge = cpha ? trail_edge : lead_edge;
    drive_edge  = cpha ? lead_edge  : trail_edge;
    load_word   = tx_full ? tx_hold : TX_IDLE;
    tx_shifted  = LSB_FIRST ? {1'b0, tx_shreg[DATA_W-1:1]}
                            : {tx_shreg[DATA_W-2:0], 1'b0};
    rx_next     = LSB_FIRST ? {mosi_s, rx_shreg[DATA_W-1:1]}
                            : {rx_shreg[DATA_W-2:0], mosi_s};
  end

  // ---------------------------------------------------------------
  // Frame FSM with registered outputs
  // ---------------------------------------------------------------
  // The host-side writes (load, rx_ack) are applied first; later
  // assignments in the same clk (shift register load, word completion)
  // deliberately take priority over them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      mode_q         <= MODE0;
      tx_hold        <= '0;
      tx_full        <= 1'b0;
      tx_shreg       <= '0;
      rx_shreg       <= '0;
      bit_cnt        <= '0;
      reload_pending <= 1'b0;
      miso_gate      <= 1'b0;
      MISO           <= 1'b0;
      rx             <= '0;
      rx_valid       <= 1'b0;
      done           <= 1'b0;
      overrun        <= 1'b0;
      underrun       <= 1'b0;
      busy           <= 1'b0;
    end else begin
      done     <= 1'b0;
      overrun  <= 1'b0;
      underrun <= 1'b0;

      if (rx_ack) begin
        rx_valid <= 1'b0;
      end
      if (load) begin
        tx_hold <= data_in;
        tx_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          MISO           <= 1'b0;
          busy           <= 1'b0;
          bit_cnt        <= '0;
          reload_pending <= 1'b0;
          if (cs_fall) begin
            state     <= SHIFT;
            busy      <= 1'b1;
            mode_q    <= mode;
            tx_shreg  <= load_word;
            underrun  <= ~tx_full;
            if (!load) begin
              tx_full <= 1'b0;
            end
            // CPHA=1 withholds bit 0 until the first leading edge.
            miso_gate <= mode[0];
            MISO      <= mode[0] ? 1'b0 : first_bit(load_word);
          end
        end

        SHIFT: begin
          if (cs_rise) begin
            // Abort: partial bits are dropped, holding register kept.
            state          <= IDLE;
            busy           <= 1'b0;
            MISO           <= 1'b0;
            bit_cnt        <= '0;
            reload_pending <= 1'b0;
            miso_gate      <= 1'b0;
          end else begin
            if (sample_edge) begin
              rx_shreg <= rx_next;
              if (bit_cnt == LAST_BIT) begin
                bit_cnt        <= '0;
                reload_pending <= 1'b1;
                rx             <= rx_next;
                rx_valid       <= 1'b1;
                done           <= 1'b1;
                overrun        <= rx_valid & ~rx_ack;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end

            if (drive_edge) begin
              if (reload_pending) begin
                // Word boundary: next word goes straight onto MISO.
                reload_pending <= 1'b0;
                tx_shreg       <= load_word;
                underrun       <= ~tx_full;
                if (!load) begin
                  tx_full <= 1'b0;
                end
                MISO <= first_bit(load_word);
              end else if (miso_gate) begin
                miso_gate <= 1'b0;
                MISO      <= first_bit(tx_shreg);
              end else begin
                tx_shreg <= tx_shifted;
                MISO     <= first_bit(tx_shifted);
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_param.sv
// tb_spi_slave_param
// Directed bench for spi_slave_param: an 8-bit MSB-first instance (A) and
// a 16-bit LSB-first instance (B) share the master pins, with CS steered
// to one of them. Expected RX words are queued before each frame and
// checked by per-instance monitors when done pulses.
module tb_spi_slave_param;
  import spi_pkg::*;

  localparam int unsigned H = 8;  // SCLK half-period in clk cycles

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       sclk, cs, mosi, sel, rx_ack;
  logic [1:0] mode;
  logic       cs_a, cs_b, ack_a, ack_b, miso_sel;

  logic        load_a, tx_full_a, rx_valid_a, done_a, ovr_a, und_a, busy_a, miso_a;
  logic [7:0]  data_in_a, rx_a;
  logic        load_b, tx_full_b, rx_valid_b, done_b, ovr_b, und_b, busy_b, miso_b;
  logic [15:0] data_in_b, rx_b;

  assign cs_a     = sel ? 1'b1 : cs;
  assign cs_b     = sel ? cs : 1'b1;
  assign ack_a    = ~sel & rx_ack;
  assign ack_b    = sel & rx_ack;
  assign miso_sel = sel ? miso_b : miso_a;

  spi_slave_param #(.DATA_W(8), .LSB_FIRST(1'b0), .TX_IDLE(8'h00)) dut_a (
    .clk(clk), .rst_n(rst_n), .SCLK(sclk), .CS(cs_a), .MOSI(mosi), .MISO(miso_a),
    .mode(mode), .load(load_a), .data_in(data_in_a), .tx_full(tx_full_a),
    .rx(rx_a), .rx_valid(rx_valid_a), .rx_ack(ack_a), .done(done_a),
    .overrun(ovr_a), .underrun(und_a), .busy(busy_a)
  );

  spi_slave_param #(.DATA_W(16), .LSB_FIRST(1'b1), .TX_IDLE(16'h0000)) dut_b (
    .clk(clk), .rst_n(rst_n), .SCLK(sclk), .CS(cs_b), .MOSI(mosi), .MISO(miso_b),
    .mode(mode), .load(load_b), .data_in(data_in_b), .tx_full(tx_full_b),
    .rx(rx_b), .rx_valid(rx_valid_b), .rx_ack(ack_b), .done(done_b),
    .overrun(ovr_b), .underrun(und_b), .busy(busy_b)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [15:0] rx;
    logic        ovr;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   done_cnt_a = 0, und_cnt_a = 0, ovr_cnt_a = 0;

  always @(negedge clk) begin
    if (done_a) done_cnt_a++;
    if (und_a)  und_cnt_a++;
    if (ovr_a)  ovr_cnt_a++;
  end

  always @(negedge clk) begin
    if (done_a) begin
      if (qa.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL done_a_unexpected: got done with rx %h, required no pending word", rx_a);
      end else begin
        ea = qa.pop_front();
        check("rx_a", {24'h0, rx_a}, {16'h0, ea.rx});
        check("overrun_a", {31'h0, ovr_a}, {31'h0, ea.ovr});
        check("rx_valid_at_done_a", {31'h0, rx_valid_a}, 32'h1);
      end
    end
  end

  always @(negedge clk) begin
    if (done_b) begin
      if (qb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL done_b_unexpected: got done with rx %h, required no pending word", rx_b);
      end else begin
        eb = qb.pop_front();
        check("rx_b", {16'h0, rx_b}, {16'h0, eb.rx});
        check("overrun_b", {31'h0, ovr_b}, {31'h0, eb.ovr});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_word_a(input logic [7:0] v);
    data_in_a = v;
    load_a    = 1'b1;
    ticks(1);
    load_a    = 1'b0;
  endtask

  task automatic load_word_b(input logic [15:0] v);
    data_in_b = v;
    load_b    = 1'b1;
    ticks(1);
    load_b    = 1'b0;
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    ticks(1);
    rx_ack = 1'b0;
    ticks(1);
  endtask

  // Wire order: bit k of the result is the k-th bit on the wire.
  function automatic logic [31:0] wire_bits(input logic [15:0] w, input int width, input bit lsb);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < width; k++) r[k] = lsb ? w[k] : w[width-1-k];
    return r;
  endfunction

  // One CS-low frame of nbits; seq[k] is driven on MOSI, got[k] is MISO
  // captured at the k-th sample edge. ack_last places a one-clk rx_ack on
  // the clk where the slave registers completion of the final bit.
  task automatic frame(input logic [1:0] m, input int nbits, input logic [31:0] seq,
                       input bit ack_last, output logic [31:0] got);
    got  = '0;
    mode = m;
    sclk = m[1];
    ticks(4);
    cs = 1'b0;
    ticks(H);
    for (int i = 0; i < nbits; i++) begin
      if (!m[0]) begin
        mosi = seq[i];
        ticks(H);
        got[i] = miso_sel;
        sclk   = ~m[1];
      end else begin
        sclk = ~m[1];
        mosi = seq[i];
        ticks(H);
        got[i] = miso_sel;
        sclk   = m[1];
      end
      if (ack_last && i == nbits - 1) begin
        ticks(3);
        rx_ack = 1'b1;
        ticks(1);
        rx_ack = 1'b0;
        ticks(H - 4);
      end else begin
        ticks(H);
      end
      if (!m[0]) sclk = m[1];
    end
    if (!m[0]) ticks(H);
    cs = 1'b1;
    ticks(H);
  endtask

  task automatic check_reset_a();
    check("rst_miso",     {31'h0, miso_a},     32'h0);
    check("rst_tx_full",  {31'h0, tx_full_a},  32'h0);
    check("rst_rx",       {24'h0, rx_a},       32'h0);
    check("rst_rx_valid", {31'h0, rx_valid_a}, 32'h0);
    check("rst_done",     {31'h0, done_a},     32'h0);
    check("rst_overrun",  {31'h0, ovr_a},      32'h0);
    check("rst_underrun", {31'h0, und_a},      32'h0);
    check("rst_busy",     {31'h0, busy_a},     32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required end of test");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  logic [31:0] got;
  logic [1:0]  modes [3];
  int          d0, u0, o0;

  initial begin
    rst_n = 1'b0; sclk = 1'b0; cs = 1'b1; mosi = 1'b0; sel = 1'b0; rx_ack = 1'b0;
    mode = MODE0; load_a = 1'b0; load_b = 1'b0; data_in_a = '0; data_in_b = '0;
    modes[0] = MODE0; modes[1] = MODE1; modes[2] = MODE2;
    @(negedge clk);
    ticks(4);
    check_reset_a();
    rst_n = 1'b1;
    ticks(6);

    // Mode 3: 0xB3 out, 0xCA in (wire 1,1,0,0,1,0,1,0 -> 0x53 in wire order)
    load_word_a(8'hB3);
    check("tx_full_after_load", {31'h0, tx_full_a}, 32'h1);
    u0 = und_cnt_a;
    qa.push_back('{rx: 16'h00CA, ovr: 1'b0});
    fork
      frame(MODE3, 8, 32'h53, 1'b0, got);
      begin ticks(20); check("busy_mid_frame", {31'h0, busy_a}, 32'h1); end
    join
    check("miso_mode3", got, 32'hCD);
    check("tx_full_consumed", {31'h0, tx_full_a}, 32'h0);
    check("underrun_none_mode3", u0, und_cnt_a);
    ack_pulse();

    // Same transfer in modes 0, 1, 2
    foreach (modes[j]) begin
      load_word_a(8'hB3);
      qa.push_back('{rx: 16'h00CA, ovr: 1'b0});
      frame(modes[j], 8, 32'h53, 1'b0, got);
      check($sformatf("miso_mode%0d", j), got, 32'hCD);
      ack_pulse();
    end

    // Two-word burst, only 0xB3 held, no ack between words
    load_word_a(8'hB3);
    d0 = done_cnt_a;
    u0 = und_cnt_a;
    qa.push_back('{rx: 16'h003C, ovr: 1'b0});
    qa.push_back('{rx: 16'h0081, ovr: 1'b1});
    frame(MODE3, 16, wire_bits(16'h3C, 8, 1'b0) | (wire_bits(16'h81, 8, 1'b0) << 8), 1'b0, got);
    check("miso_burst", got, 32'h0000_00CD);
    check("burst_underruns", und_cnt_a - u0, 1);
    check("burst_dones", done_cnt_a - d0, 2);
    check("burst_rx_final", {24'h0, rx_a}, 32'h81);

    // rx_ack in the completion clk: no overrun, rx_valid stays set
    load_word_a(8'hB3);
    o0 = ovr_cnt_a;
    qa.push_back('{rx: 16'h0066, ovr: 1'b0});
    frame(MODE3, 8, wire_bits(16'h66, 8, 1'b0), 1'b1, got);
    check("ack_coincident_no_overrun", ovr_cnt_a - o0, 0);
    check("ack_coincident_rx_valid", {31'h0, rx_valid_a}, 32'h1);
    ack_pulse();

    // Abort after 5 bits with a word loaded mid-frame, then a full frame
    d0 = done_cnt_a;
    fork
      frame(MODE0, 5, 32'h1F, 1'b0, got);
      begin ticks(40); load_word_a(8'h77); end
    join
    check("abort_no_done", done_cnt_a - d0, 0);
    check("abort_tx_full_kept", {31'h0, tx_full_a}, 32'h1);
    check("abort_rx_kept", {24'h0, rx_a}, 32'h66);
    check("abort_rx_valid", {31'h0, rx_valid_a}, 32'h0);
    check("abort_busy", {31'h0, busy_a}, 32'h0);
    qa.push_back('{rx: 16'h005A, ovr: 1'b0});
    frame(MODE0, 8, wire_bits(16'h5A, 8, 1'b0), 1'b0, got);
    check("miso_after_abort", got, 32'hEE);
    check("tx_full_after_abort_frame", {31'h0, tx_full_a}, 32'h0);

    // Reset mid-frame (rx_valid left set, a word loaded during the frame)
    fork
      frame(MODE2, 8, wire_bits(16'hC3, 8, 1'b0), 1'b0, got);
      begin
        ticks(30);
        load_word_a(8'h99);
        ticks(20);
        rst_n = 1'b0;
        ticks(3);
        check_reset_a();
        rst_n = 1'b1;
      end
    join
    ticks(6);
    load_word_a(8'hB3);
    qa.push_back('{rx: 16'h00CA, ovr: 1'b0});
    frame(MODE2, 8, 32'h53, 1'b0, got);
    check("miso_after_reset", got, 32'hCD);
    ack_pulse();

    // 16-bit LSB-first instance: 0x1234 in, 0xA5C3 out, bit 0 first
    sel = 1'b1;
    ticks(2);
    load_word_b(16'hA5C3);
    qb.push_back('{rx: 16'h1234, ovr: 1'b0});
    frame(MODE1, 16, 32'h0000_1234, 1'b0, got);
    check("miso_b_lsb_first", got, 32'h0000_A5C3);
    check("rx_b_final", {16'h0, rx_b}, 32'h1234);
    check("tx_full_b", {31'h0, tx_full_b}, 32'h0);
    ack_pulse();

    ticks(10);
    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
